// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch
// port and the load/store data port. Only one access is outstanding at a time.
// Read data comes back a fixed MEM_LAT cycles (1..4) after issue.
module mem_arbiter #(
  parameter int WA      = 32,
  parameter int WD      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [WA-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [WD-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [WA-1:0] d_addr,
  input  logic [WD-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [WD-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [WA-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [WD-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lastData_q, lastData_d;
  logic       ownerData_q, ownerData_d;

  logic respCycle;
  logic contested;
  logic pickData;
  logic issue;

  // The response cycle frees the port, so a new access may issue in that same cycle.
  // On a tie, the requester that lost the last contested grant wins.
  always_comb begin
    respCycle = !rst && (state_q == ST_WAIT) && (cnt_q == LatCnt);
    contested = if_req && d_req;
    pickData  = d_req && (!if_req || !lastData_q);
    issue     = !rst && (if_req || d_req) && ((state_q == ST_IDLE) || respCycle);
  end

  // Drive the grant, memory-port and response outputs.
  // The memory port idles at zero outside issue cycles.
  always_comb begin
    if_gnt    = issue && !pickData;
    d_gnt     = issue && pickData;
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (issue) begin
      if (pickData) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end else begin
        mem_addr  = if_addr;
        mem_be    = 4'b1111;
      end
    end
    if_valid = respCycle && !ownerData_q;
    d_valid  = respCycle && ownerData_q;
    if_rdata = if_valid ? mem_rdata : '0;
    d_rdata  = d_valid ? mem_rdata : '0;
    busy     = issue || (!rst && (state_q == ST_WAIT) && !respCycle);
  end

  // Next state: an issue restarts the cycle counter at 1 and records the owner.
  // The response cycle returns the arbiter to idle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastData_d  = lastData_q;
    ownerData_d = ownerData_q;
    if (issue) begin
      state_d     = ST_WAIT;
      cnt_d       = 3'd1;
      ownerData_d = pickData;
      if (contested) begin
        lastData_d = pickData;
      end
    end else if (respCycle) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // State registers. Reset abandons any outstanding access and points the tie-breaker at fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      lastData_q  <= 1'b0;
      ownerData_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastData_q  <= lastData_d;
      ownerData_q <= ownerData_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: four arbiter instances, one per MEM_LAT value 1..4, each with its own RAM model.
// Each instance is driven by a directed sequence.
// Responses are checked against a queue of expected results.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        ifReq    [1:4];
  logic [31:0] ifAddr   [1:4];
  logic        ifGnt    [1:4];
  logic        ifValid  [1:4];
  logic [31:0] ifRdata  [1:4];
  logic        dReq     [1:4];
  logic        dWe      [1:4];
  logic [31:0] dAddr    [1:4];
  logic [31:0] dWdata   [1:4];
  logic [3:0]  dBe      [1:4];
  logic        dGnt     [1:4];
  logic        dValid   [1:4];
  logic [31:0] dRdata   [1:4];
  logic        memEn    [1:4];
  logic        memWe    [1:4];
  logic [31:0] memAddr  [1:4];
  logic [31:0] memWdata [1:4];
  logic [3:0]  memBe    [1:4];
  logic [31:0] memRdata [1:4];
  logic        busy     [1:4];

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t ifQ[$];
  exp_t dQ[$];
  int   cyc         = 0;
  int   assertCount = 0;
  int   failCount   = 0;

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] ramInit(int i);
    if (i == 4) return 32'h0050_0093;
    return 32'hC0DE_0000 | (32'(i) << 2);
  endfunction

  function automatic logic [31:0] expWord(logic [31:0] addr);
    return ramInit(int'(addr[9:2]));
  endfunction

  for (genvar L = 1; L <= 4; L++) begin : lane
    logic [31:0] ram  [0:255];
    logic [31:0] pipe [0:3];

    mem_arbiter #(.WA(32), .WD(32), .MEM_LAT(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (ifReq[L]),
      .if_addr  (ifAddr[L]),
      .if_gnt   (ifGnt[L]),
      .if_valid (ifValid[L]),
      .if_rdata (ifRdata[L]),
      .d_req    (dReq[L]),
      .d_we     (dWe[L]),
      .d_addr   (dAddr[L]),
      .d_wdata  (dWdata[L]),
      .d_be     (dBe[L]),
      .d_gnt    (dGnt[L]),
      .d_valid  (dValid[L]),
      .d_rdata  (dRdata[L]),
      .mem_en   (memEn[L]),
      .mem_we   (memWe[L]),
      .mem_addr (memAddr[L]),
      .mem_wdata(memWdata[L]),
      .mem_be   (memBe[L]),
      .mem_rdata(memRdata[L]),
      .busy     (busy[L])
    );

    // Synchronous RAM model
    // Contents are reloaded during reset.
    // Byte-enabled writes are supported.
    // Read data is delayed through an L-deep pipe.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) ram[i] <= ramInit(i);
        for (int k = 0; k < 4; k++) pipe[k] <= 32'h0;
      end else begin
        if (memEn[L] && memWe[L]) begin
          for (int b = 0; b < 4; b++) begin
            if (memBe[L][b]) ram[memAddr[L][9:2]][8*b +: 8] <= memWdata[L][8*b +: 8];
          end
        end
        pipe[0] <= (memEn[L] && !memWe[L]) ? ram[memAddr[L][9:2]] : 32'hBAD0_0000;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign memRdata[L] = pipe[L-1];
  end

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(int L, bit ir, logic [31:0] ia, bit dr, bit dw,
                               logic [31:0] da, logic [31:0] dwd, logic [3:0] db);
    ifReq[L]  = ir;
    ifAddr[L] = ia;
    dReq[L]   = dr;
    dWe[L]    = dw;
    dAddr[L]  = da;
    dWdata[L] = dwd;
    dBe[L]    = db;
  endtask

  task automatic idleInputs(int L);
    applyStimulus(L, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic beginCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pushIf(int L, logic [31:0] data, bit chk);
    exp_t e;
    e.due  = cyc + L;
    e.data = data;
    e.chk  = chk;
    ifQ.push_back(e);
  endtask

  task automatic pushD(int L, logic [31:0] data, bit chk);
    exp_t e;
    e.due  = cyc + L;
    e.data = data;
    e.chk  = chk;
    dQ.push_back(e);
  endtask

  task automatic endCycle(int L);
    exp_t e;
    bit   expV;
    #4;
    expV = (ifQ.size() > 0) && (ifQ[0].due == cyc);
    checkOutput("if_valid", 32'(ifValid[L]), 32'(expV));
    if (expV) begin
      e = ifQ.pop_front();
      if (e.chk) checkOutput("if_rdata", ifRdata[L], e.data);
    end
    expV = (dQ.size() > 0) && (dQ[0].due == cyc);
    checkOutput("d_valid", 32'(dValid[L]), 32'(expV));
    if (expV) begin
      e = dQ.pop_front();
      if (e.chk) checkOutput("d_rdata", dRdata[L], e.data);
    end
  endtask

  task automatic expectGrants(int L, bit eIf, bit eD);
    checkOutput("if_gnt", 32'(ifGnt[L]), 32'(eIf));
    checkOutput("d_gnt", 32'(dGnt[L]), 32'(eD));
    checkOutput("mem_en", 32'(memEn[L]), 32'(eIf | eD));
  endtask

  // Watchdog so the run can never hang
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    rst = 1'b1;
    for (int L = 1; L <= 4; L++) idleInputs(L);

    // Reset: every lane idles at zero
    beginCycle();
    endCycle(1);
    beginCycle();
    endCycle(1);
    for (int L = 1; L <= 4; L++) begin
      expectGrants(L, 1'b0, 1'b0);
      checkOutput("reset busy", 32'(busy[L]), 32'h0);
    end
    beginCycle();
    rst = 1'b0;
    endCycle(1);

    // MEM_LAT=1 single fetch
    beginCycle();
    applyStimulus(1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endCycle(1);
    expectGrants(1, 1'b1, 1'b0);
    checkOutput("t1 mem_addr", memAddr[1], 32'h10);
    checkOutput("t1 mem_we", 32'(memWe[1]), 32'h0);
    checkOutput("t1 mem_be", 32'(memBe[1]), 32'hF);
    checkOutput("t1 mem_wdata", memWdata[1], 32'h0);
    checkOutput("t1 busy", 32'(busy[1]), 32'h1);
    pushIf(1, 32'h0050_0093, 1'b1);
    beginCycle();
    idleInputs(1);
    endCycle(1);
    expectGrants(1, 1'b0, 1'b0);
    checkOutput("t1 busy after", 32'(busy[1]), 32'h0);
    beginCycle();
    endCycle(1);

    // MEM_LAT=3 partial store, then read back
    beginCycle();
    applyStimulus(3, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3);
    endCycle(3);
    expectGrants(3, 1'b0, 1'b1);
    checkOutput("t2 mem_we", 32'(memWe[3]), 32'h1);
    checkOutput("t2 mem_be", 32'(memBe[3]), 32'h3);
    checkOutput("t2 mem_addr", memAddr[3], 32'h100);
    checkOutput("t2 mem_wdata", memWdata[3], 32'hDEAD_BEEF);
    checkOutput("t2 busy", 32'(busy[3]), 32'h1);
    pushD(3, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      beginCycle();
      idleInputs(3);
      endCycle(3);
      expectGrants(3, 1'b0, 1'b0);
      checkOutput("t2 busy wait", 32'(busy[3]), (k < 3) ? 32'h1 : 32'h0);
    end
    beginCycle();
    applyStimulus(3, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    endCycle(3);
    expectGrants(3, 1'b0, 1'b1);
    checkOutput("t2 load mem_we", 32'(memWe[3]), 32'h0);
    pushD(3, 32'hC0DE_BEEF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      beginCycle();
      idleInputs(3);
      endCycle(3);
    end

    // MEM_LAT=2 both requesters held high: D,F,D,F
    for (int k = 0; k < 9; k++) begin
      bit eD;
      bit eF;
      beginCycle();
      if (k < 8) applyStimulus(2, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      else idleInputs(2);
      endCycle(2);
      eD = (k < 8) && (k % 4 == 0);
      eF = (k < 8) && (k % 4 == 2);
      expectGrants(2, eF, eD);
      checkOutput("t3 busy", 32'(busy[2]), (k < 8) ? 32'h1 : 32'h0);
      if (eD) pushD(2, expWord(32'h40), 1'b1);
      if (eF) pushIf(2, expWord(32'h20), 1'b1);
    end

    // MEM_LAT=1 back-to-back fetches
    for (int k = 0; k < 5; k++) begin
      beginCycle();
      if (k < 3) applyStimulus(1, 1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      else idleInputs(1);
      endCycle(1);
      expectGrants(1, k < 3, 1'b0);
      if (k < 3) pushIf(1, expWord(32'(4 * k)), 1'b1);
    end

    // MEM_LAT=4: a contested data win, then a fetch abandoned by reset, then a tie
    for (int k = 0; k < 14; k++) begin
      beginCycle();
      if (k == 0 || k == 9) applyStimulus(4, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      else if (k <= 4 || k == 6) applyStimulus(4, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      else idleInputs(4);
      rst = (k == 6);
      endCycle(4);
      expectGrants(4, k == 4, k == 0 || k == 9);
      if (k == 0 || k == 9) pushD(4, expWord(32'h40), 1'b1);
      if (k == 4) checkOutput("t5 mem_addr", memAddr[4], 32'h10);
      if (k == 6) begin
        checkOutput("t5 rst busy", 32'(busy[4]), 32'h0);
        checkOutput("t5 rst mem_addr", memAddr[4], 32'h0);
        checkOutput("t5 rst mem_be", 32'(memBe[4]), 32'h0);
        checkOutput("t5 rst if_rdata", ifRdata[4], 32'h0);
      end
      if (k == 7 || k == 8) checkOutput("t5 busy idle", 32'(busy[4]), 32'h0);
    end

    // MEM_LAT=1: a request during reset is held off until reset drops
    beginCycle();
    rst = 1'b1;
    applyStimulus(1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endCycle(1);
    expectGrants(1, 1'b0, 1'b0);
    beginCycle();
    rst = 1'b0;
    endCycle(1);
    expectGrants(1, 1'b1, 1'b0);
    pushIf(1, 32'h0050_0093, 1'b1);
    beginCycle();
    idleInputs(1);
    endCycle(1);
    beginCycle();
    endCycle(1);

    checkOutput("if queue drained", 32'(ifQ.size()), 32'h0);
    checkOutput("d queue drained", 32'(dQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store data port.
- Sits between the PC/fetch stage and the data-memory path, and is the first step toward a unified-memory core.
- Runs one access at a time, with a configurable fixed memory read latency and req/gnt/valid handshakes on each requester.

Parameters:
WA, 32, byte-address width of both requester ports and the memory port
WD, 32, data width (fixed at 32; byte enables are 4 bits)
MEM_LAT, 1, RAM latency in cycles from issue to read data, legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  WA  fetch byte address
if_gnt  output  1  one-cycle pulse: fetch issued to memory this cycle
if_valid  output  1  one-cycle pulse: if_rdata holds the fetched word
if_rdata  output  WD  fetched instruction
d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  WA  data byte address
d_wdata  input  WD  store data
d_be  input  4  store byte enables
d_gnt  output  1  one-cycle pulse: data access issued this cycle
d_valid  output  1  one-cycle pulse: load data ready or store complete
d_rdata  output  WD  load data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  WA  memory byte address
mem_wdata  output  WD  memory write data
mem_be  output  4  memory byte enables
mem_rdata  input  WD  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  an access is outstanding

Behaviour:
- States:
  - IDLE: free, may grant.
  - WAIT: access outstanding; counter cnt (3 bits) counts cycles since issue.
- Issue (cycle t):
  - Issue happens in IDLE, or in the response cycle of a previous access, when any request is high.
  - The arbiter selects one requester and, combinationally in the same cycle, drives mem_en=1, the matching gnt=1, and the mem_* fields from that requester.
  - A fetch drives mem_we=0, mem_be=4'b1111, mem_wdata=0.
  - A data access passes d_we, d_addr, d_wdata and d_be through.
  - In every cycle that is not an issue cycle, mem_en, mem_we, mem_addr, mem_wdata and mem_be are 0.
- Response:
  - The valid of the granted port pulses for exactly one cycle, in cycle t+MEM_LAT.
  - The matching rdata equals mem_rdata in that cycle. rdata is passed through combinationally and is meaningful only while valid=1.
  - A store also produces d_valid at t+MEM_LAT, as a completion ack.
  - A new issue is allowed in the same cycle as the response. Maximum throughput is one access per MEM_LAT cycles.
- busy is 1 from cycle t+1 through t+MEM_LAT-1, and also in cycle t when MEM_LAT>1. With MEM_LAT=1, busy is high only in issue cycles.
- Arbitration:
  - If only one request is high, that requester wins.
  - If both are high, round-robin: the requester that did not win the last contested grant wins.
  - The last-grant pointer updates only on contested grants and resets to "fetch", so the first tie after reset goes to data.
- Requesters must hold req and their fields stable until gnt. A req deasserted before gnt is legal and is simply not served.
- Reset:
  - rst=1 forces the state to IDLE, cnt=0, pointer=fetch.
  - All outputs are 0 during reset, and no gnt is issued.
  - Reset while in WAIT abandons the access: no valid pulse is ever produced for it.
- A requester re-asserting req in its own valid cycle is eligible for that same cycle.

Test Plan:
- MEM_LAT=1, if_req=1, if_addr=0x0000_0010, RAM[0x10]=0x0050_0093 -> cycle t: if_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0, mem_be=4'hF; t+1: if_valid=1, if_rdata=0x0050_0093.
- MEM_LAT=3, d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'h3 -> d_gnt at t; mem_we=1, mem_be=4'h3; busy=1 at t..t+2; d_valid=1 at t+3 only; a later read of 0x100 returns 0x????_BEEF, with the upper half unchanged.
- MEM_LAT=2, both requests held high continuously after reset -> grants alternate D,F,D,F at cycles t, t+2, t+4, t+6; each valid pulses two cycles after its gnt; no two gnts in the same cycle.
- MEM_LAT=1, back-to-back fetches at addresses 0x0, 0x4, 0x8 -> if_gnt high three consecutive cycles; if_valid high three consecutive cycles, one cycle later; data returned in order.
- MEM_LAT=4, fetch issued at t, rst=1 at t+2 for one cycle -> no if_valid at t+4; all outputs 0 during the rst cycle; a new request after reset is granted normally, and a tie goes to data.
- Single cycle with rst=1 while if_req=1 -> if_gnt=0 and mem_en=0 in that cycle; grant occurs in the first cycle after rst drops.
